// File: rtl/processor_status.sv
// 6502 processor status register (P).
// Holds C, Z, I, D, V and N. The flags load from the ALU, from the internal
// data bus or from decoder set/clear strobes. P is driven onto the bus for
// pushes, and a copy of I is delayed to the instruction boundary for IRQ
// polling. Bits 5 and 4 of P are not stored and always read as 1.
module processor_status #(
  parameter logic [7:0] RESET_P = 8'h34
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_db,
  input  logic       i_acr,
  input  logic       i_avr,
  input  logic       i_ir5,
  input  logic       i_db0_c,
  input  logic       i_ir5_c,
  input  logic       i_acr_c,
  input  logic       i_dbz_z,
  input  logic       i_db1_z,
  input  logic       i_db2_i,
  input  logic       i_ir5_i,
  input  logic       i_set_i,
  input  logic       i_db3_d,
  input  logic       i_ir5_d,
  input  logic       i_db6_v,
  input  logic       i_avr_v,
  input  logic       i_clr_v,
  input  logic       i_db7_n,
  input  logic       i_sync,
  input  logic       i_p_db,
  input  logic       i_brk_bit,
  output logic [7:0] o_p,
  output logic [7:0] o_db,
  output logic       o_carry,
  output logic       o_decimal,
  output logic       o_irq_mask
);

  logic flag_c, flag_z, flag_i, flag_d, flag_v, flag_n;
  logic irq_mask;

  // Flag registers. Each flag has its own priority chain and holds when none
  // of its controls is active.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      flag_c <= RESET_P[0];
      flag_z <= RESET_P[1];
      flag_i <= RESET_P[2];
      flag_d <= RESET_P[3];
      flag_v <= RESET_P[6];
      flag_n <= RESET_P[7];
    end else begin
      if (i_acr_c)      flag_c <= i_acr;
      else if (i_db0_c) flag_c <= i_db[0];
      else if (i_ir5_c) flag_c <= i_ir5;

      if (i_dbz_z)      flag_z <= (i_db == 8'h00);
      else if (i_db1_z) flag_z <= i_db[1];

      if (i_set_i)      flag_i <= 1'b1;
      else if (i_db2_i) flag_i <= i_db[2];
      else if (i_ir5_i) flag_i <= i_ir5;

      if (i_db3_d)      flag_d <= i_db[3];
      else if (i_ir5_d) flag_d <= i_ir5;

      if (i_clr_v)      flag_v <= 1'b0;
      else if (i_avr_v) flag_v <= i_avr;
      else if (i_db6_v) flag_v <= i_db[6];

      if (i_db7_n)      flag_n <= i_db[7];
    end
  end

  // IRQ mask samples I only at the opcode fetch, so a write to I takes effect
  // for polling one instruction later; a write on the same edge is not seen.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      irq_mask <= 1'b1;
    end else if (i_sync) begin
      irq_mask <= flag_i;
    end
  end

  // Status views. The pushed byte reflects P before any update on the
  // coming edge, with bit 4 distinguishing BRK/PHP from IRQ/NMI.
  always_comb begin
    o_p        = {flag_n, flag_v, 2'b11, flag_d, flag_i, flag_z, flag_c};
    o_db       = 8'hFF;
    if (i_p_db) begin
      o_db = {flag_n, flag_v, 1'b1, i_brk_bit, flag_d, flag_i, flag_z, flag_c};
    end
    o_carry    = flag_c;
    o_decimal  = flag_d;
    o_irq_mask = irq_mask;
  end

endmodule

// File: tb/tb_processor_status.sv
// Directed bench for the 6502 status register.
module tb_processor_status;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic [7:0] i_db;
  logic       i_acr, i_avr, i_ir5;
  logic       i_db0_c, i_ir5_c, i_acr_c;
  logic       i_dbz_z, i_db1_z;
  logic       i_db2_i, i_ir5_i, i_set_i;
  logic       i_db3_d, i_ir5_d;
  logic       i_db6_v, i_avr_v, i_clr_v;
  logic       i_db7_n;
  logic       i_sync, i_p_db, i_brk_bit;
  logic [7:0] o_p, o_db;
  logic       o_carry, o_decimal, o_irq_mask;

  int checks = 0;
  int errors = 0;

  processor_status dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_db(i_db),
    .i_acr(i_acr), .i_avr(i_avr), .i_ir5(i_ir5),
    .i_db0_c(i_db0_c), .i_ir5_c(i_ir5_c), .i_acr_c(i_acr_c),
    .i_dbz_z(i_dbz_z), .i_db1_z(i_db1_z),
    .i_db2_i(i_db2_i), .i_ir5_i(i_ir5_i), .i_set_i(i_set_i),
    .i_db3_d(i_db3_d), .i_ir5_d(i_ir5_d),
    .i_db6_v(i_db6_v), .i_avr_v(i_avr_v), .i_clr_v(i_clr_v),
    .i_db7_n(i_db7_n), .i_sync(i_sync), .i_p_db(i_p_db),
    .i_brk_bit(i_brk_bit),
    .o_p(o_p), .o_db(o_db), .o_carry(o_carry), .o_decimal(o_decimal),
    .o_irq_mask(o_irq_mask)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_db = 8'h00; i_acr = 0; i_avr = 0; i_ir5 = 0;
    i_db0_c = 0; i_ir5_c = 0; i_acr_c = 0;
    i_dbz_z = 0; i_db1_z = 0;
    i_db2_i = 0; i_ir5_i = 0; i_set_i = 0;
    i_db3_d = 0; i_ir5_d = 0;
    i_db6_v = 0; i_avr_v = 0; i_clr_v = 0;
    i_db7_n = 0; i_sync = 0; i_p_db = 0; i_brk_bit = 0;
  endtask

  // Let the current inputs be captured, then sample 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    idle();
    i_reset_n = 1'b0;
    tick();
    check("reset_p_held", o_p, 8'h34);
    tick();
    i_reset_n = 1'b1;
    tick();
    check("reset_p", o_p, 8'h34);
    check("reset_mask", o_irq_mask, 1'b1);
    check("reset_db_idle", o_db, 8'hFF);
    check("reset_carry", o_carry, 1'b0);

    // Z/N from the data bus
    i_db = 8'h00; i_dbz_z = 1; i_db7_n = 1;
    tick();
    check("zn_zero", o_p, 8'h36);
    i_db = 8'h80;
    tick();
    check("zn_neg", o_p, 8'hB4);

    // ALU carry/overflow, then CLV beats avr_v
    idle();
    i_acr = 1; i_avr = 1; i_acr_c = 1; i_avr_v = 1;
    tick();
    check("alu_carry", o_carry, 1'b1);
    check("alu_p", o_p, 8'hF5);
    idle();
    i_avr = 1; i_clr_v = 1; i_avr_v = 1;
    tick();
    check("clv_wins", o_p, 8'hB5);

    // C priority: acr_c over db0_c, then db0_c over ir5_c
    idle();
    i_acr = 0; i_acr_c = 1; i_db0_c = 1; i_db = 8'h01;
    tick();
    check("c_acr_prio", o_p, 8'hB4);
    idle();
    i_db = 8'h00; i_db0_c = 1; i_ir5 = 1; i_ir5_c = 1;
    tick();
    check("c_db0_prio", o_carry, 1'b0);

    // PLP then push
    idle();
    i_db = 8'hCB;
    i_db0_c = 1; i_db1_z = 1; i_db2_i = 1; i_db3_d = 1; i_db6_v = 1; i_db7_n = 1;
    tick();
    check("plp", o_p, 8'hFB);
    idle();
    i_p_db = 1; i_brk_bit = 0;
    #1;
    check("push_irq", o_db, 8'hEB);
    i_brk_bit = 1;
    #1;
    check("push_brk", o_db, 8'hFB);

    // Pushed byte is P before a same-edge update
    i_db = 8'h00; i_db7_n = 1;
    #1;
    check("push_old", o_db, 8'hFB);
    tick();
    check("push_after", o_p, 8'h7B);

    // I priority
    idle();
    i_set_i = 1; i_db2_i = 1; i_db = 8'h00;
    tick();
    check("i_set_prio", o_p, 8'h7F);
    idle();
    i_db2_i = 1; i_ir5_i = 1; i_ir5 = 1; i_db = 8'h00;
    tick();
    check("i_db2_prio", o_p, 8'h7B);
    check("mask_no_sync", o_irq_mask, 1'b1);

    // SEI, CLI without sync, then boundary
    idle();
    i_ir5 = 1; i_ir5_i = 1;
    tick();
    check("sei", o_p, 8'h7F);
    idle();
    i_ir5 = 0; i_ir5_i = 1;
    tick();
    check("cli", o_p, 8'h7B);
    check("cli_mask_hold", o_irq_mask, 1'b1);
    idle();
    i_sync = 1;
    tick();
    check("cli_mask_sync", o_irq_mask, 1'b0);

    // SEI on the boundary edge: mask takes old I
    i_ir5 = 1; i_ir5_i = 1;
    tick();
    check("sei_same_edge_i", o_p, 8'h7F);
    check("sei_same_edge_mask", o_irq_mask, 1'b0);
    idle();
    i_sync = 1;
    tick();
    check("sei_next_sync", o_irq_mask, 1'b1);
    i_ir5 = 0; i_ir5_i = 1;
    tick();
    check("cli_same_edge_mask", o_irq_mask, 1'b1);
    idle();
    i_sync = 1;
    tick();
    check("cli_next_sync", o_irq_mask, 1'b0);

    // D and Z priority
    idle();
    i_db = 8'h00; i_db3_d = 1; i_ir5 = 1; i_ir5_d = 1;
    tick();
    check("d_prio", o_p, 8'h73);
    check("d_prio_dec", o_decimal, 1'b0);
    idle();
    i_db = 8'h02; i_dbz_z = 1; i_db1_z = 1;
    tick();
    check("z_prio", o_p, 8'h71);

    // SED+SEC, then reset in the middle of a pending update
    idle();
    i_ir5 = 1; i_ir5_d = 1; i_ir5_c = 1;
    tick();
    check("sed_sec", o_p, 8'h79);
    check("sed_dec", o_decimal, 1'b1);
    idle();
    i_db = 8'h80; i_db7_n = 1; i_ir5 = 1; i_ir5_i = 1; i_sync = 1;
    #3;
    i_reset_n = 1'b0;
    #1;
    check("async_reset_p", o_p, 8'h34);
    check("async_reset_mask", o_irq_mask, 1'b1);
    check("async_reset_carry", o_carry, 1'b0);
    check("async_reset_dec", o_decimal, 1'b0);
    check("async_reset_db", o_db, 8'hFF);
    tick();
    check("reset_hold_edge", o_p, 8'h34);
    idle();
    i_reset_n = 1'b1;
    tick();
    check("post_reset", o_p, 8'h34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
